// File: rtl/keypad_decoder.sv
// -----------------------------------------------------------------------------
// keypad_decoder
//
// Purpose:
//   Decodes a scanned 4x4 matrix keypad. The external row scanner drives one
//   row per clock (one-hot) and marks each frame boundary with 1111. The raw
//   column sense lines are synchronised, paired with their delayed row phase,
//   and reduced to one result per frame (no key, one key, or ghost). A
//   debounce state machine turns the frame results into accepted key events.
//
// Optional feature:
//   KEY_REPEAT_EN - when defined, a held key re-issues key_valid every
//                   REPEAT_FRAMES closed frames with key_code unchanged.
//
// Parameters:
//   DEBOUNCE_FRAMES - identical frames needed to accept a press/release (2..15)
//   REPEAT_FRAMES   - frames between auto-repeat pulses (2..255)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   fila_tecla in   [3:0] row drive: 1111 boundary, 1000..0001 rows 0..3
//   columna    in   [3:0] raw column sense, active-high, bit 3 = column 0
//   key_code   out  [3:0] 4*row + column of last accepted key
//   key_valid  out  one-clock pulse per accepted press (and per repeat)
//   key_held   out  high while a debounced key is considered pressed
// -----------------------------------------------------------------------------
module keypad_decoder #(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] fila_tecla,
    input  logic [3:0] columna,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);

    if (DEBOUNCE_FRAMES < 2 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
        $error("keypad_decoder: DEBOUNCE_FRAMES must be in 2..15");
    end
    if (REPEAT_FRAMES < 2 || REPEAT_FRAMES > 255) begin : g_bad_repeat
        $error("keypad_decoder: REPEAT_FRAMES must be in 2..255");
    end

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Bit 3 is index 0 for both rows and columns.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // ---------------------------------------------------------------------
    // Column synchroniser and matching row delay
    // ---------------------------------------------------------------------
    logic [3:0] col_s1_q, col_s2_q;
    logic [3:0] row_d1_q, row_d2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= 4'b0000;
            col_s2_q <= 4'b0000;
            row_d1_q <= 4'b1111;
            row_d2_q <= 4'b1111;
        end else begin
            col_s1_q <= columna;
            col_s2_q <= col_s1_q;
            row_d1_q <= fila_tecla;
            row_d2_q <= row_d1_q;
        end
    end

    logic       row_onehot;
    logic       frame_close;
    logic [2:0] col_ones;

    assign row_onehot  = (row_d2_q == 4'b1000) || (row_d2_q == 4'b0100) ||
                         (row_d2_q == 4'b0010) || (row_d2_q == 4'b0001);
    assign frame_close = (row_d2_q == 4'b1111);
    assign col_ones    = popcount4(col_s2_q);

    // ---------------------------------------------------------------------
    // Per-frame accumulator. Phases that are neither one-hot nor 1111 fall
    // through both branches and leave the accumulator untouched.
    // ---------------------------------------------------------------------
    logic       acc_hit_q,   acc_hit_d;
    logic       acc_ghost_q, acc_ghost_d;
    logic       acc_rows_q,  acc_rows_d;
    logic [3:0] acc_code_q,  acc_code_d;

    always_comb begin
        acc_hit_d   = acc_hit_q;
        acc_ghost_d = acc_ghost_q;
        acc_rows_d  = acc_rows_q;
        acc_code_d  = acc_code_q;
        if (frame_close) begin
            acc_hit_d   = 1'b0;
            acc_ghost_d = 1'b0;
            acc_rows_d  = 1'b0;
            acc_code_d  = 4'd0;
        end else if (row_onehot) begin
            acc_rows_d = 1'b1;
            if (col_ones >= 3'd2) begin
                acc_ghost_d = 1'b1;
            end else if (col_ones == 3'd1) begin
                if (acc_hit_q) begin
                    acc_ghost_d = 1'b1;
                end else begin
                    acc_hit_d  = 1'b1;
                    acc_code_d = {onehot_idx(row_d2_q), onehot_idx(col_s2_q)};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hit_q   <= 1'b0;
            acc_ghost_q <= 1'b0;
            acc_rows_q  <= 1'b0;
            acc_code_q  <= 4'd0;
        end else begin
            acc_hit_q   <= acc_hit_d;
            acc_ghost_q <= acc_ghost_d;
            acc_rows_q  <= acc_rows_d;
            acc_code_q  <= acc_code_d;
        end
    end

    // Frame result, valid in the frame-close cycle.
    logic res_key, res_ghost;
    assign res_ghost = acc_ghost_q;
    assign res_key   = acc_hit_q && !acc_ghost_q;

    // ---------------------------------------------------------------------
    // Debounce state machine, evaluated at frame close only
    // ---------------------------------------------------------------------
    state_t     state_q;
    logic [3:0] frame_cnt_q;
    logic [3:0] cand_q;
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic       key_held_q;
    // Set by reset: closes are ignored until one frame that actually carried
    // row phases has closed, so a frame cut by reset never counts.
    logic       partial_q;
    logic [3:0] cnt_inc;

    assign cnt_inc = sat_inc4(frame_cnt_q);

`ifdef KEY_REPEAT_EN
    localparam logic [7:0] REP_N = 8'(REPEAT_FRAMES);
    logic [7:0] rep_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= 4'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            partial_q   <= 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt_q   <= 8'd0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (frame_close) begin
                if (partial_q) begin
                    if (acc_rows_q) begin
                        partial_q <= 1'b0;
                    end
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (res_key) begin
                                state_q     <= DEB_PRESS;
                                frame_cnt_q <= 4'd1;
                                cand_q      <= acc_code_q;
                            end
                        end
                        DEB_PRESS: begin
                            if (res_key && acc_code_q == cand_q) begin
                                if (cnt_inc >= DEB_N) begin
                                    state_q     <= PRESSED;
                                    frame_cnt_q <= 4'd0;
                                    key_code_q  <= cand_q;
                                    key_valid_q <= 1'b1;
                                    key_held_q  <= 1'b1;
`ifdef KEY_REPEAT_EN
                                    rep_cnt_q   <= 8'd0;
`endif
                                end else begin
                                    frame_cnt_q <= cnt_inc;
                                end
                            end else if (res_key) begin
                                cand_q      <= acc_code_q;
                                frame_cnt_q <= 4'd1;
                            end else begin
                                state_q     <= IDLE;
                                frame_cnt_q <= 4'd0;
                            end
                        end
                        PRESSED: begin
                            if (res_ghost || (res_key && acc_code_q == key_code_q)) begin
                                frame_cnt_q <= 4'd0;
`ifdef KEY_REPEAT_EN
                                if (rep_cnt_q >= REP_N - 8'd1) begin
                                    rep_cnt_q   <= 8'd0;
                                    key_valid_q <= 1'b1;
                                end else begin
                                    rep_cnt_q <= rep_cnt_q + 8'd1;
                                end
`endif
                            end else begin
                                state_q     <= DEB_RELEASE;
                                frame_cnt_q <= 4'd1;
                            end
                        end
                        DEB_RELEASE: begin
                            if (res_key && acc_code_q == key_code_q) begin
                                state_q     <= PRESSED;
                                frame_cnt_q <= 4'd0;
`ifdef KEY_REPEAT_EN
                                rep_cnt_q   <= 8'd0;
`endif
                            end else if (!res_ghost) begin
                                // No key or a different key both count toward
                                // release; a ghost frame carries no information.
                                if (cnt_inc >= DEB_N) begin
                                    state_q     <= IDLE;
                                    frame_cnt_q <= 4'd0;
                                    key_held_q  <= 1'b0;
                                end else begin
                                    frame_cnt_q <= cnt_inc;
                                end
                            end
                        end
                        default: begin
                            state_q     <= IDLE;
                            frame_cnt_q <= 4'd0;
                            key_held_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_decoder
//
// Directed bench for keypad_decoder. A behavioural keypad turns the driven row
// and the set of pressed keys into column levels. Frames are 1111 followed by
// rows 0..3, one per clock. A monitor records, for every key_valid pulse, the
// number of the frame whose close produced it.
// -----------------------------------------------------------------------------
module tb_keypad_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  fila_tecla = 4'b1111;
    logic [3:0]  columna;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys = 16'h0000;
    int          frame_idx = 0;
    int          pulse_frames[$];
    int          wide_cnt = 0;
    logic        kv_prev = 1'b0;
    int          checks = 0;
    int          errors = 0;

    keypad_decoder #(
        .DEBOUNCE_FRAMES(4),
        .REPEAT_FRAMES  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fila_tecla(fila_tecla),
        .columna   (columna),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        columna = 4'b0000;
        if (fila_tecla != 4'b1111) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (fila_tecla[3-r] && keys[4*r+c]) columna[3-c] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulse_frames.push_back(frame_idx - 1);
            if (kv_prev) wide_cnt <= wide_cnt + 1;
        end
        kv_prev <= key_valid;
    end

    task automatic scan_frame(input logic [15:0] pressed, input bit inject);
        frame_idx++;
        @(negedge clk);
        keys       = pressed;
        fila_tecla = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            fila_tecla = 4'b1000 >> r;
            if (inject && r == 1) begin
                @(negedge clk);
                fila_tecla = 4'b0110;
            end
        end
    endtask

    task automatic scan_n(input int n, input logic [15:0] pressed);
        for (int i = 0; i < n; i++) scan_frame(pressed, 1'b0);
    endtask

    task automatic start_case();
        frame_idx = 0;
        pulse_frames.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (key_code !== 4'd0) begin
            errors++; $display("FAIL reset_key_code: got %0d expected 0", key_code);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid);
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL reset_key_held: got %b expected 0", key_held);
        end
        rst_n = 1'b1;
        scan_n(1, 16'h0000);
    endtask

    task automatic test_basic_press();
        start_case();
        scan_n(6, 16'h0200);
        scan_n(1, 16'h0000);
        checks++;
        if (pulse_frames.size() != 1) begin
            errors++; $display("FAIL basic_pulse_count: got %0d expected 1", pulse_frames.size());
        end
        checks++;
        if ((pulse_frames.size() > 0 ? pulse_frames[0] : -1) != 4) begin
            errors++; $display("FAIL basic_pulse_frame: got %0d expected 4",
                               pulse_frames.size() > 0 ? pulse_frames[0] : -1);
        end
        checks++;
        if (key_code !== 4'd9) begin
            errors++; $display("FAIL basic_key_code: got %0d expected 9", key_code);
        end
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL basic_key_held: got %b expected 1", key_held);
        end
        scan_n(6, 16'h0000);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL basic_release_held: got %b expected 0", key_held);
        end
        checks++;
        if (key_code !== 4'd9) begin
            errors++; $display("FAIL basic_code_hold: got %0d expected 9", key_code);
        end
    endtask

    task automatic test_short_press();
        start_case();
        scan_n(2, 16'h0020);
        scan_n(1, 16'h0000);
        scan_n(3, 16'h0020);
        scan_n(1, 16'h0000);
        checks++;
        if (pulse_frames.size() != 0) begin
            errors++; $display("FAIL short_no_pulse: got %0d expected 0", pulse_frames.size());
        end
        scan_n(4, 16'h0020);
        scan_n(1, 16'h0000);
        checks++;
        if ((pulse_frames.size() == 1 ? pulse_frames[0] : -1) != 11) begin
            errors++; $display("FAIL short_retry_frame: got count %0d first %0d expected one pulse at 11",
                               pulse_frames.size(), pulse_frames.size() > 0 ? pulse_frames[0] : -1);
        end
        checks++;
        if (key_code !== 4'd5) begin
            errors++; $display("FAIL short_key_code: got %0d expected 5", key_code);
        end
        scan_n(6, 16'h0000);
    endtask

    task automatic test_ghost();
        start_case();
        scan_n(8, 16'h0050);
        scan_n(1, 16'h0000);
        checks++;
        if (pulse_frames.size() != 0) begin
            errors++; $display("FAIL ghost_row_pulse: got %0d expected 0", pulse_frames.size());
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL ghost_row_held: got %b expected 0", key_held);
        end
        scan_n(6, 16'h0202);
        scan_n(2, 16'h0000);
        checks++;
        if (pulse_frames.size() != 0) begin
            errors++; $display("FAIL ghost_two_rows_pulse: got %0d expected 0", pulse_frames.size());
        end
    endtask

    task automatic test_invalid_row();
        start_case();
        for (int i = 0; i < 5; i++) scan_frame(16'h0200, 1'b1);
        scan_n(1, 16'h0000);
        checks++;
        if ((pulse_frames.size() == 1 ? pulse_frames[0] : -1) != 4) begin
            errors++; $display("FAIL invalid_row_frame: got count %0d first %0d expected one pulse at 4",
                               pulse_frames.size(), pulse_frames.size() > 0 ? pulse_frames[0] : -1);
        end
        checks++;
        if (key_code !== 4'd9) begin
            errors++; $display("FAIL invalid_row_code: got %0d expected 9", key_code);
        end
        scan_n(6, 16'h0000);
    endtask

    task automatic test_back_to_back();
        start_case();
        scan_n(5, 16'h0200);
        scan_n(5, 16'h0040);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL b2b_held_drop: got %b expected 0", key_held);
        end
        scan_n(3, 16'h0040);
        scan_n(1, 16'h0000);
        checks++;
        if (pulse_frames.size() != 2) begin
            errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulse_frames.size());
        end
        checks++;
        if ((pulse_frames.size() > 1 ? pulse_frames[1] : -1) != 13) begin
            errors++; $display("FAIL b2b_second_frame: got %0d expected 13",
                               pulse_frames.size() > 1 ? pulse_frames[1] : -1);
        end
        checks++;
        if (key_code !== 4'd6) begin
            errors++; $display("FAIL b2b_key_code: got %0d expected 6", key_code);
        end
        scan_n(6, 16'h0000);
    endtask

    task automatic test_bounce_release();
        start_case();
        scan_n(5, 16'h0008);
        scan_n(1, 16'h0000);
        scan_n(1, 16'h0008);
        scan_n(4, 16'h0000);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL bounce_held_3none: got %b expected 1", key_held);
        end
        scan_n(1, 16'h0000);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL bounce_held_4none: got %b expected 0", key_held);
        end
        checks++;
        if (pulse_frames.size() != 1) begin
            errors++; $display("FAIL bounce_pulse_count: got %0d expected 1", pulse_frames.size());
        end
        checks++;
        if (key_code !== 4'd3) begin
            errors++; $display("FAIL bounce_key_code: got %0d expected 3", key_code);
        end
        scan_n(2, 16'h0000);
    endtask

    task automatic test_reset_mid_press();
        // Reset in DEB_PRESS of key 12, in the middle of a frame.
        start_case();
        scan_n(2, 16'h1000);
        @(negedge clk); keys = 16'h1000; fila_tecla = 4'b1111;
        @(negedge clk); fila_tecla = 4'b1000;
        @(negedge clk); fila_tecla = 4'b0100;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (key_code !== 4'd0) begin
            errors++; $display("FAIL midreset_code: got %0d expected 0", key_code);
        end
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: got valid %b held %b expected 0 0", key_valid, key_held);
        end
        @(negedge clk); rst_n = 1'b1; fila_tecla = 4'b0010;
        @(negedge clk); fila_tecla = 4'b0001;
        start_case();
        scan_n(5, 16'h1000);
        checks++;
        if ((pulse_frames.size() == 1 ? pulse_frames[0] : -1) != 4) begin
            errors++; $display("FAIL midreset_accept_frame: got count %0d first %0d expected one pulse at 4",
                               pulse_frames.size(), pulse_frames.size() > 0 ? pulse_frames[0] : -1);
        end
        checks++;
        if (key_code !== 4'd12 || key_held !== 1'b1) begin
            errors++; $display("FAIL midreset_accept_code: got code %0d held %b expected 12 1", key_code, key_held);
        end
        // Reset while PRESSED must drop the outputs at once.
        @(negedge clk); fila_tecla = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (key_held !== 1'b0 || key_code !== 4'd0) begin
            errors++; $display("FAIL pressed_reset: got code %0d held %b expected 0 0", key_code, key_held);
        end
        @(negedge clk); rst_n = 1'b1;
        scan_n(2, 16'h0000);
    endtask

    task automatic test_repeat();
        int exp_q[$];
`ifdef KEY_REPEAT_EN
        exp_q = '{4, 36, 68, 100};
`else
        exp_q = '{4};
`endif
        start_case();
        scan_n(100, 16'h0001);
        scan_n(1, 16'h0000);
        checks++;
        if (pulse_frames.size() != exp_q.size()) begin
            errors++; $display("FAIL repeat_count: got %0d expected %0d", pulse_frames.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ((i < pulse_frames.size() ? pulse_frames[i] : -1) != exp_q[i]) begin
                errors++; $display("FAIL repeat_frame_%0d: got %0d expected %0d", i,
                                   i < pulse_frames.size() ? pulse_frames[i] : -1, exp_q[i]);
            end
        end
        checks++;
        if (key_code !== 4'd0) begin
            errors++; $display("FAIL repeat_key_code: got %0d expected 0", key_code);
        end
        scan_n(6, 16'h0000);
    endtask

    task automatic test_pulse_width();
        checks++;
        if (wide_cnt != 0) begin
            errors++; $display("FAIL pulse_width: got %0d multi-clock pulses expected 0", wide_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_short_press();
        test_ghost();
        test_invalid_row();
        test_back_to_back();
        test_bounce_release();
        test_reset_mid_press();
        test_repeat();
        test_pulse_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
